uart_cmd_wrapper: RTL and testbench

- Robot-side end of the remote command link; RemoteComm is the initiator at the other end.
- Receives two UART bytes, high byte first, and assembles them into a 16-bit command for cmd_proc using a cmd_rdy/clr_cmd_rdy handshake.
- Serializes the 8-bit response byte (0xA5 = done) back to RemoteComm.
- Contains its own bit-level UART receiver and transmitter, 8N1.

---
 rtl/uart_cmd_wrapper.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - 8N1 UART receiver/transmitter with two-byte command assembly for cmd_proc.
// Optional WAIT_LO timeout under CMD_TIMEOUT_EN.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604,
    parameter int TMO_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);
    localparam int CW = $clog2(BAUD_DIV + 1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_e;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_e;

    rx_state_e   rx_state_q;
    asm_state_e  asm_q;
    tx_state_e   tx_state_q;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_idx_q;
    logic [7:0]    rx_shift_q;
    logic          rx_valid_q;
    logic [7:0]    hi_q;
    logic [15:0]   cmd_q;
    logic          cmd_rdy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_idx_q;
    logic [9:0]    tx_shift_q;
    logic          tx_q;
    logic          tx_done_q;
    logic          start_det;

    assign start_det = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_s2_q;
    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign tx_done   = tx_done_q;

    // Preset to idle-high so the first cycles after reset never look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (start_det) begin
                        rx_state_q <= RX_RECV;
                        rx_cnt_q   <= CW'(BAUD_DIV / 2);
                        rx_idx_q   <= 4'd0;
                    end
                end
                RX_RECV: begin
                    if (rx_cnt_q == CW'(1)) begin
                        rx_cnt_q <= CW'(BAUD_DIV);
                        if (rx_idx_q == 4'd0) begin
                            if (rx_s2_q) rx_state_q <= RX_IDLE;
                            else         rx_idx_q   <= 4'd1;
                        end else if (rx_idx_q <= 4'd8) begin
                            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                            rx_idx_q   <= rx_idx_q + 4'd1;
                        end else begin
                            // A low stop bit is a framing error: the byte is dropped silently.
                            rx_valid_q <= rx_s2_q;
                            rx_state_q <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end
                end
            endcase
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TMO_BITS + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic [TW-1:0] tmo_bits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q  <= CW'(BAUD_DIV);
            tmo_bits_q <= '0;
        end else if (asm_q != WAIT_LO || rx_state_q != RX_IDLE || start_det) begin
            tmo_cnt_q  <= CW'(BAUD_DIV);
            tmo_bits_q <= '0;
        end else if (tmo_cnt_q == CW'(1)) begin
            tmo_cnt_q  <= CW'(BAUD_DIV);
            tmo_bits_q <= tmo_bits_q + TW'(1);
        end else begin
            tmo_cnt_q <= tmo_cnt_q - CW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= WAIT_HI;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            case (asm_q)
                WAIT_HI: begin
                    if (rx_valid_q) begin
                        hi_q  <= rx_shift_q;
                        asm_q <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rx_valid_q) begin
                        cmd_q <= {hi_q, rx_shift_q};
                        asm_q <= WAIT_HI;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (tmo_bits_q == TW'(TMO_BITS)) begin
                        asm_q <= WAIT_HI;
                    end
`endif
                end
            endcase
            // A fresh completion outranks both clear sources.
            if (rx_valid_q && asm_q == WAIT_LO)
                cmd_rdy_q <= 1'b1;
            else if (clr_cmd_rdy || (start_det && asm_q == WAIT_HI))
                cmd_rdy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '1;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (trmt) begin
                        tx_shift_q <= {1'b1, resp, 1'b0};
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= CW'(BAUD_DIV);
                        tx_idx_q   <= 4'd0;
                        tx_done_q  <= 1'b0;
                        tx_state_q <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_cnt_q == CW'(1)) begin
                        tx_cnt_q <= CW'(BAUD_DIV);
                        if (tx_idx_q == 4'd9) begin
                            tx_q       <= 1'b1;
                            tx_done_q  <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                            tx_q       <= tx_shift_q[1];
                            tx_idx_q   <= tx_idx_q + 4'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - directed self-checking bench for uart_cmd_wrapper (short baud divisor).
module tb_uart_cmd_wrapper;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
    logic [15:0] cmd;
    logic [7:0]  resp;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          start_cyc = 0;
    logic [9:0]  frame;

    uart_cmd_wrapper #(.BAUD_DIV(B), .TMO_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge cmd_rdy) rise_cyc = cyc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 RX = 1'b0;
        repeat (B) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(posedge clk);
            #1;
        end
        RX = stop;
        repeat (B) @(posedge clk);
        #1 RX = 1'b1;
    endtask

    task automatic settle();
        repeat (B) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", TX, 1);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_cmd", cmd, 0);
        rst_n = 1'b1;
        settle();

        // Basic command plus latency window
        @(posedge clk); start_cyc = cyc;
        send_byte(8'h2F, 1'b1);
        send_byte(8'hFF, 1'b1);
        settle();
        check("cmd_2fff_rdy", cmd_rdy, 1);
        check("cmd_2fff", cmd, 16'h2FFF);
        check("cmd_2fff_latency", ((rise_cyc - start_cyc) >= 19 * B) && ((rise_cyc - start_cyc) <= 21 * B), 1);
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        check("clr_drops_rdy", cmd_rdy, 0);
        check("cmd_held_after_clr", cmd, 16'h2FFF);

        // Unacknowledged command is withdrawn at the next high-byte start edge
        send_byte(8'h41, 1'b1);
        send_byte(8'h23, 1'b1);
        settle();
        check("cmd_4123_rdy", cmd_rdy, 1);
        check("cmd_4123", cmd, 16'h4123);
        fork
            send_byte(8'h34, 1'b1);
            begin
                repeat (10) @(posedge clk);
                #1;
                check("start_edge_clears_rdy", cmd_rdy, 0);
                check("cmd_stable_on_clear", cmd, 16'h4123);
            end
        join
        send_byte(8'h56, 1'b1);
        settle();
        check("cmd_3456_rdy", cmd_rdy, 1);
        check("cmd_3456", cmd, 16'h3456);

        // Response frame, with a stray trmt mid-frame
        resp = 8'hA5;
        frame = 10'b1_1010_0101_0;
        @(posedge clk); #1 trmt = 1'b1;
        @(posedge clk); #1 trmt = 1'b0;
        check("tx_done_cleared", tx_done, 0);
        for (int i = 0; i < 10; i++) begin
            repeat (B / 2) @(posedge clk);
            #1;
            check($sformatf("tx_bit%0d", i), TX, frame[i]);
            if (i == 9) check("tx_done_before_end", tx_done, 0);
            if (i == 4) begin
                trmt = 1'b1; resp = 8'h00;
                @(posedge clk); #1 trmt = 1'b0;
                repeat (B / 2 - 1) @(posedge clk);
            end else begin
                repeat (B / 2) @(posedge clk);
            end
        end
        #1;
        check("tx_done_set", tx_done, 1);
        check("tx_idle_high", TX, 1);
        repeat (3 * B) @(posedge clk);
        #1;
        check("tx_done_held", tx_done, 1);

        // Framing error on the high byte
        send_byte(8'h77, 1'b0);
        settle();
        check("framing_rdy_low", cmd_rdy, 0);
        send_byte(8'h12, 1'b1);
        settle();
        check("hi_only_no_rdy", cmd_rdy, 0);
        send_byte(8'h34, 1'b1);
        settle();
        check("cmd_1234_rdy", cmd_rdy, 1);
        check("cmd_1234", cmd, 16'h1234);

        // Reset in the middle of a low byte and a response frame
        send_byte(8'hAA, 1'b1);
        @(posedge clk); #1 RX = 1'b0;
        repeat (3 * B) @(posedge clk);
        #1 resp = 8'h3C; trmt = 1'b1;
        @(posedge clk); #1 trmt = 1'b0;
        repeat (B) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", TX, 1);
        check("midrst_rdy", cmd_rdy, 0);
        check("midrst_cmd", cmd, 0);
        RX = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b1);
        settle();
        check("cmd_5a5a_rdy", cmd_rdy, 1);
        check("cmd_5a5a", cmd, 16'h5A5A);
        check("tx_idle_after_rst", TX, 1);

        // Long gap between high and low byte
        send_byte(8'hAB, 1'b1);
        repeat (33 * B) @(posedge clk);
        send_byte(8'hCD, 1'b1);
        settle();
`ifdef CMD_TIMEOUT_EN
        check("tmo_late_byte_is_hi", cmd_rdy, 0);
        send_byte(8'hEF, 1'b1);
        settle();
        check("tmo_cmd_rdy", cmd_rdy, 1);
        check("tmo_cmd", cmd, 16'hCDEF);
`else
        check("notmo_cmd_rdy", cmd_rdy, 1);
        check("notmo_cmd", cmd, 16'hABCD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
